// File: rtl/seq_alu_pkg.sv
// Shared definitions for the seq_alu execute stage: op codes, flag bit positions
// and FSM state encoding. The FLAGS register and the decoder import the same indices.
package seq_alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_MUL  = 3'b101,
      OP_DIV  = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ITER = 2'b01,
      DONE = 2'b10
   } state_e;

   function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                             input logic n, input logic z);
      logic [3:0] f;
      f         = '0;
      f[FLAG_V] = v;
      f[FLAG_C] = c;
      f[FLAG_N] = n;
      f[FLAG_Z] = z;
      return f;
   endfunction

endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider datapath: one step per
// cycle when told to, with the next-step values exposed so the FSM can finish in step.
module muldiv_iter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             load,
   input  logic             step,
   input  logic             div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] nxt_hi,
   output logic [WIDTH-1:0] nxt_lo,
   output logic             div_mode,
   output logic             zero_next
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] hi_q, lo_q, opb_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   sum, shifted, diff;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, opb_q};
      nxt_hi  = sum[WIDTH:1];
      nxt_lo  = {sum[0], lo_q[WIDTH-1:1]};
      if (div_mode) begin
         // diff[WIDTH] is the borrow: remainder trial failed, restore.
         if (!diff[WIDTH]) begin
            nxt_hi = diff[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = shifted[WIDTH-1:0];
            nxt_lo = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign zero_next = (cnt_q == CW'(1));

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         cnt_q    <= '0;
         div_mode <= 1'b0;
      end else if (load) begin
         hi_q     <= '0;
         lo_q     <= a;
         opb_q    <= b;
         cnt_q    <= CW'(WIDTH);
         div_mode <= div;
      end else if (step) begin
         hi_q  <= nxt_hi;
         lo_q  <= nxt_lo;
         cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/seq_alu.sv
// 16-bit execute-stage ALU feeding the FLAGS register: single-cycle logic/arithmetic,
// iterative MUL/DIV, registered result/flags with a one-cycle done/flags_en strobe.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FLAGW = 4
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [FLAGW-1:0] flags_out,
   output logic             flags_en
);

   state_e           state;
   op_e              op_in;
   logic             is_iter, load;
   logic [WIDTH:0]   add_w, sub_w;
   logic [WIDTH-1:0] sc_res, md_hi, md_lo;
   logic             sc_c, sc_v, md_div, md_last;
   logic [FLAGW-1:0] sc_flags, md_flags;

   assign op_in   = op_e'(op);
   assign is_iter = (op_in == OP_MUL) || ((op_in == OP_DIV) && (b != '0));
   assign load    = (state == IDLE) && start && is_iter;

   always_comb begin
      add_w  = {1'b0, a} + {1'b0, b};
      sub_w  = {1'b0, a} - {1'b0, b};
      sc_res = a;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (op_in)
         OP_ADD: begin
            sc_res = add_w[WIDTH-1:0];
            sc_c   = add_w[WIDTH];
            sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // Top bit of the zero-extended difference is the borrow (a < b).
            sc_res = sub_w[WIDTH-1:0];
            sc_c   = sub_w[WIDTH];
            sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         default: sc_res = a;
      endcase
      sc_flags = pack_flags(sc_v, sc_c, sc_res[WIDTH-1], sc_res == '0);
   end

   always_comb begin
      if (md_div)
         md_flags = pack_flags(1'b0, 1'b0, md_lo[WIDTH-1], md_lo == '0);
      else
         md_flags = pack_flags(md_hi != '0, md_hi != '0, md_lo[WIDTH-1],
                               {md_hi, md_lo} == '0);
   end

   muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
      .clk       (clk),
      .rst_b     (rst_b),
      .load      (load),
      .step      (state == ITER),
      .div       (op_in == OP_DIV),
      .a         (a),
      .b         (b),
      .nxt_hi    (md_hi),
      .nxt_lo    (md_lo),
      .div_mode  (md_div),
      .zero_next (md_last)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         result_hi <= '0;
         flags_out <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy <= 1'b1;
               if (is_iter) begin
                  state <= ITER;
               end else if (op_in == OP_DIV) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  result    <= '1;
                  result_hi <= a;
                  flags_out <= pack_flags(1'b1, 1'b0, 1'b1, 1'b0);
               end else begin
                  state     <= DONE;
                  done      <= 1'b1;
                  result    <= sc_res;
                  result_hi <= '0;
                  flags_out <= sc_flags;
               end
            end
            // The last step's values go straight to the outputs, saving a cycle.
            ITER: if (md_last) begin
               state     <= DONE;
               done      <= 1'b1;
               result    <= md_lo;
               result_hi <= md_hi;
               flags_out <= md_flags;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign flags_en = done;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu: hand-computed results, flags, latency,
// ignored/accepted start timing and asynchronous abort.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        start;
   logic [2:0]  op;
   logic [15:0] a, b;
   logic        busy, done, flags_en;
   logic [15:0] result, result_hi;
   logic [3:0]  flags_out;

   int tests = 0;
   int fails = 0;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, MUL = 3'b101, DIV = 3'b110, PASS = 3'b111;

   seq_alu dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .result_hi (result_hi),
      .flags_out (flags_out),
      .flags_en  (flags_en)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents start for one edge; returns 1 ns after that edge with inputs scrambled.
   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      @(negedge clk);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = ADD; a = 16'hA5A5; b = 16'h5A5A;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] x,
                         input logic [15:0] y, input int lat_exp, input logic [15:0] r_exp,
                         input logic [15:0] h_exp, input logic [3:0] f_exp);
      int lat;
      issue(o, x, y);
      wait_done(lat);
      check({tag, " latency"}, lat, lat_exp);
      check({tag, " result"}, result, r_exp);
      check({tag, " result_hi"}, result_hi, h_exp);
      check({tag, " flags"}, flags_out, f_exp);
      check({tag, " flags_en"}, flags_en, 1'b1);
      @(posedge clk);
      #1;
      check({tag, " done pulse"}, {done, flags_en, busy}, 3'b000);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n_done, first_done, busy_cnt;
      logic [15:0] cap_r, cap_h;
      logic [3:0]  cap_f;

      rst_b = 1'b0; start = 1'b0; op = ADD; a = '0; b = '0;
      #12;
      check("reset outputs", {busy, done, flags_en, result, result_hi, flags_out}, '0);
      @(negedge clk);
      rst_b = 1'b1;

      run_op("add ovf", ADD, 16'h7FFF, 16'h0001, 1, 16'h8000, 16'h0000, 4'b1010);
      run_op("add carry", ADD, 16'hFFFF, 16'h0001, 1, 16'h0000, 16'h0000, 4'b0101);
      run_op("sub zero", SUB, 16'h0005, 16'h0005, 1, 16'h0000, 16'h0000, 4'b0001);
      run_op("sub borrow", SUB, 16'h0000, 16'h0001, 1, 16'hFFFF, 16'h0000, 4'b0110);
      run_op("xor", XOR_, 16'hFFFF, 16'h0001, 1, 16'hFFFE, 16'h0000, 4'b0010);
      run_op("pass", PASS, 16'h0000, 16'h1234, 1, 16'h0000, 16'h0000, 4'b0001);

      // MUL with a stray ADD start while busy.
      issue(MUL, 16'h0100, 16'h0100);
      n_done = 0; first_done = 0; busy_cnt = 0;
      cap_r = '0; cap_h = '0; cap_f = '0;
      for (int k = 1; k <= 20; k++) begin
         if (busy) busy_cnt++;
         if (done) begin
            n_done++;
            if (first_done == 0) begin
               first_done = k;
               cap_r = result; cap_h = result_hi; cap_f = flags_out;
            end
         end
         if (k == 5) begin
            start = 1'b1; op = ADD; a = 16'h0001; b = 16'h0001;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
      end
      check("mul done cycle", first_done, 17);
      check("mul done count", n_done, 1);
      check("mul busy cycles", busy_cnt, 17);
      check("mul result", cap_r, 16'h0000);
      check("mul result_hi", cap_h, 16'h0001);
      check("mul flags", cap_f, 4'b1100);

      run_op("mul max", MUL, 16'hFFFF, 16'hFFFF, 17, 16'h0001, 16'hFFFE, 4'b1100);
      run_op("div 100/7", DIV, 16'd100, 16'd7, 17, 16'h000E, 16'h0002, 4'b0000);
      run_op("div by one", DIV, 16'hFFFF, 16'h0001, 17, 16'hFFFF, 16'h0000, 4'b0010);
      run_op("div by zero", DIV, 16'h1234, 16'h0000, 1, 16'hFFFF, 16'h1234, 4'b1010);

      // Abort a MUL in cycle t+8.
      issue(MUL, 16'h1234, 16'h5678);
      repeat (7) @(posedge clk);
      #1;
      check("abort busy before", busy, 1'b1);
      rst_b = 1'b0;
      #1;
      check("abort async outputs", {busy, done, flags_en, result, result_hi, flags_out}, '0);
      @(negedge clk);
      rst_b = 1'b1;
      n_done = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (done) n_done++;
      end
      check("abort no done", n_done, 0);
      check("abort idle", busy, 1'b0);
      run_op("add after abort", ADD, 16'h0002, 16'h0003, 1, 16'h0005, 16'h0000, 4'b0000);

      // AND, then OR held through the done cycle (ignored) and accepted one cycle later.
      issue(AND_, 16'hF0F0, 16'h0F0F);
      check("b2b and done", done, 1'b1);
      check("b2b and result", result, 16'h0000);
      check("b2b and flags", flags_out, 4'b0001);
      start = 1'b1; op = OR_; a = 16'hF0F0; b = 16'h0F0F;
      @(posedge clk);
      #1;
      check("b2b gap", {done, result}, {1'b0, 16'h0000});
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b or done", done, 1'b1);
      check("b2b or result", result, 16'hFFFF);
      check("b2b or flags", flags_out, 4'b0010);
      @(posedge clk);
      #1;
      check("b2b or pulse", {done, flags_en}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- 16-bit execute-stage ALU, directly upstream of the 4-bit FLAGS register.
- Produces a result word and the condition flags {V,C,N,Z}, plus a one-cycle `flags_en` strobe that drives the FLAGS register enable.
- Single-cycle logic/arithmetic ops complete in 1 cycle; MUL and DIV are iterative and take 16 cycles.
- The control unit stalls on `busy`.

Parameters:
- WIDTH, 16, operand/result width; the MUL/DIV iteration count equals WIDTH.
- FLAGW, 4, flag vector width (fixed at 4).

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- start  input  1  launch an operation; sampled only when busy=0
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 DIV, 111 PASS(a)
- a  input  WIDTH  operand A (dividend for DIV)
- b  input  WIDTH  operand B (divisor for DIV)
- busy  output  1  operation in flight; start is ignored while high
- done  output  1  one-cycle pulse; result, result_hi and flags_out are valid
- result  output  WIDTH  main result (low product word, or quotient)
- result_hi  output  WIDTH  high product word, or remainder; 0 for single-cycle ops
- flags_out  output  FLAGW  [0]=Z, [1]=N, [2]=C, [3]=V; connects to the FLAGS data input
- flags_en  output  1  equals done; connects to the FLAGS enable

Behaviour:
- Reset (rst_b=0, async): state IDLE; busy=0, done=0, flags_en=0, result=0, result_hi=0, flags_out=0; iteration counter and working registers cleared.
- States:
  - IDLE: wait for start.
  - ITER: MUL/DIV iterations.
  - DONE: single-cycle pulse.
- Operands and op are latched on the start edge; later changes to a, b or op have no effect.
- IDLE + start with a single-cycle op (ADD..XOR, PASS): compute, go to DONE. done is high in cycle t+1 (start sampled at edge t); busy is high only in DONE.
- IDLE + start with MUL, or with DIV and b≠0: go to ITER with counter=WIDTH. busy is high from t+1.
  - Each cycle performs one step:
    - MUL: shift-add, unsigned.
    - DIV: restoring, unsigned.
  - The counter decrements each step; when it reaches 0, go to DONE. done is high at t+17.
- DIV with b=0: no iteration; DONE at t+1. result=0xFFFF, result_hi=a, flags V=1, C=0, Z=0, N=1.
- DONE always returns to IDLE on the next cycle.
  - A start coincident with done is ignored.
  - A start in the cycle after done is accepted.
- Outputs hold their last values until the next DONE.
- Flag rules:
  - Z=(result==0) for all ops except MUL, where Z=({result_hi,result}==0).
  - N=result[15].
  - ADD: C=carry out of bit 15; V=signed overflow.
  - SUB (a-b): C=1 iff a<b unsigned (borrow); V=signed overflow.
  - AND/OR/XOR/PASS: C=0, V=0.
  - MUL: C=V=(result_hi≠0).
  - DIV (b≠0): C=0, V=0.
- Reset mid-operation aborts immediately to IDLE with all outputs at their reset values. No done is issued for the aborted op.
- done and flags_en are never high for more than one consecutive cycle.

Decomposition:
- Shared package seq_alu_pkg holds:
  - op codes (OP_ADD..OP_PASS);
  - flag bit indices FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3;
  - state encoding IDLE/ITER/DONE.
- The FLAGS register and the decoder import the same flag indices.
- One sub-module: muldiv_iter. It holds the accumulator/remainder register, the shift register and the counter. It performs one step per cycle under the control of the seq_alu FSM, and reports zero-count.
- Single-cycle ops and flag generation stay in seq_alu.

Test Plan:
- ADD a=0x7FFF, b=0x0001 -> done at t+1, result=0x8000, flags_out=4'b1010, flags_en=1 for exactly 1 cycle.
- SUB 0x0005-0x0005 -> result=0x0000, flags=4'b0001; SUB 0x0000-0x0001 -> result=0xFFFF, flags=4'b0110.
- MUL 0x0100*0x0100 -> busy t+1..t+17, done at t+17, result=0x0000, result_hi=0x0001, flags=4'b1100. A start pulse at t+5 with op=ADD is ignored (no extra done).
- DIV 100/7 -> done at t+17, result=0x000E, result_hi=0x0002, flags=4'b0000. DIV 0x1234/0 -> done at t+1, result=0xFFFF, result_hi=0x1234, flags=4'b1010.
- Assert rst_b=0 at t+8 of a MUL -> busy, done, result, result_hi, flags_out go to 0 asynchronously. After release, an ADD 2+3 gives result=0x0005, flags=4'b0000.
- Back-to-back: start AND 0xF0F0&0x0F0F at t, start again at t+2 with OR 0xF0F0|0x0F0F -> results 0x0000 (flags=4'b0001) then 0xFFFF (flags=4'b0010). Each done is a single-cycle pulse.
